// File: rtl/sdp_mem_be.sv
// sdp_mem_be: simple-dual-port synchronous RAM with per-byte write enables,
// read latency of 1 or 2, selectable read-during-write policy, a read-valid
// strobe and a hardware clear engine that sweeps CLR_VAL into every word.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clear_req    re-run the clear sweep (honoured only while ready=1)
//   ready        1 = sweep done and ports accepted; 0 = sweep running
//   wr_en/wr_addr/wr_data/wr_be   write port with byte enables
//   rd_en/rd_addr                 read request
//   rd_data      read data, holds its value when no read completes
//   rd_valid     one-cycle strobe marking a completed read
module sdp_mem_be #(
  parameter int unsigned       ADDR_W   = 3,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       RD_LAT   = 1,
  parameter int unsigned       RDW_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned BE_W  = DATA_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                r_ready;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_wr_merged;
  logic [DATA_W-1:0]   w_rd_old;
  logic                w_rd_acc;
  logic                w_collide;

  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;

  // State register for the clear/ready controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == ST_READY);
    end
  end

  // Next-state: sweep one word per clock, leave CLEAR on the last address
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign ready = r_ready;

  // Old word at the write address with the enabled bytes replaced
  always_comb begin
    w_wr_merged = r_mem[wr_addr];
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (wr_be[b]) begin
        w_wr_merged[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // Single physical write port shared by the clear engine and the user port
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = wr_addr;
    w_mem_wdata = w_wr_merged;
    if (r_state == ST_CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_cnt;
      w_mem_wdata = CLR_VAL;
    end else if (wr_en) begin
      w_mem_we = 1'b1;
    end
  end

  // Storage array; contents are not reset, the sweep defines them
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign w_rd_old  = r_mem[rd_addr];
  assign w_rd_acc  = (r_state == ST_READY) & rd_en;
  assign w_collide = wr_en & rd_en & (wr_addr == rd_addr);

  generate
    if (RD_LAT == 1) begin : g_lat1
      // Array read on the request edge; write-first forwards the merged word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) begin
            r_rd_data <= ((RDW_MODE == 1) && w_collide) ? w_wr_merged : w_rd_old;
          end
        end
      end
    end else begin : g_lat2
      logic              r_s1_vld;
      logic [ADDR_W-1:0] r_s1_addr;
      logic              r_s1_col;
      logic [DATA_W-1:0] r_s1_word;

      // Address registered first, array read one edge later. By then the
      // colliding write has landed, so read-first keeps a snapshot of the
      // pre-write word taken on the request edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_vld   <= 1'b0;
          r_s1_addr  <= '0;
          r_s1_col   <= 1'b0;
          r_s1_word  <= '0;
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else begin
          r_s1_vld <= w_rd_acc;
          if (w_rd_acc) begin
            r_s1_addr <= rd_addr;
            r_s1_col  <= (RDW_MODE == 0) && w_collide;
            r_s1_word <= w_rd_old;
          end
          r_rd_valid <= r_s1_vld;
          if (r_s1_vld) begin
            r_rd_data <= r_s1_col ? r_s1_word : r_mem[r_s1_addr];
          end
        end
      end
    end
  endgenerate

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_sdp_mem_be.sv
// Self-checking bench for sdp_mem_be. Four instances share one stimulus
// stream and cover both read latencies, both read-during-write policies and
// distinct clear values; each is checked against a word-level memory model.
module tb_sdp_mem_be;

  localparam int          LAT   [4] = '{1, 1, 2, 2};
  localparam int          MODE  [4] = '{0, 1, 0, 1};
  localparam logic [15:0] CLR_V [4] = '{16'h0000, 16'h5A3C, 16'hFFFF, 16'h0000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [2:0]  rd_addr;

  logic        ready_o    [4];
  logic        rd_valid_o [4];
  logic [15:0] rd_data_o  [4];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_mem   [4][8];
  bit          m_ready [4];
  int          m_sweep [4];
  bit          p_vld   [4];
  logic [15:0] p_data  [4];
  bit          m_vld   [4];
  logic [15:0] m_data  [4];

  always #5 clk = ~clk;

  sdp_mem_be #(.ADDR_W(3), .DATA_W(16), .RD_LAT(1), .RDW_MODE(0), .CLR_VAL(16'h0000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_o[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]));

  sdp_mem_be #(.ADDR_W(3), .DATA_W(16), .RD_LAT(1), .RDW_MODE(1), .CLR_VAL(16'h5A3C)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_o[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]));

  sdp_mem_be #(.ADDR_W(3), .DATA_W(16), .RD_LAT(2), .RDW_MODE(0), .CLR_VAL(16'hFFFF)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_o[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[2]), .rd_valid(rd_valid_o[2]));

  sdp_mem_be #(.ADDR_W(3), .DATA_W(16), .RD_LAT(2), .RDW_MODE(1), .CLR_VAL(16'h0000)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_o[3]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[3]), .rd_valid(rd_valid_o[3]));

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_ready[k] = 1'b0;
      m_sweep[k] = 0;
      p_vld[k]   = 1'b0;
      p_data[k]  = 16'h0;
      m_vld[k]   = 1'b0;
      m_data[k]  = 16'h0;
    end
  endtask

  // Apply one clock edge's worth of behaviour using the current inputs
  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      bit          rd_now;
      logic [15:0] old_w;
      logic [15:0] new_w;
      logic [15:0] res;
      rd_now = 1'b0;
      res    = 16'h0;
      if (!rst_n) begin
        m_ready[k] = 1'b0;
        m_sweep[k] = 0;
        p_vld[k]   = 1'b0;
        m_vld[k]   = 1'b0;
        m_data[k]  = 16'h0;
      end else begin
        if (m_ready[k]) begin
          old_w = m_mem[k][rd_addr];
          new_w = m_mem[k][wr_addr];
          if (wr_be[0]) new_w[7:0]  = wr_data[7:0];
          if (wr_be[1]) new_w[15:8] = wr_data[15:8];
          rd_now = rd_en;
          res = (rd_en && wr_en && rd_addr == wr_addr && MODE[k] == 1) ? new_w : old_w;
          if (wr_en) m_mem[k][wr_addr] = new_w;
          if (clear_req) begin
            m_ready[k] = 1'b0;
            m_sweep[k] = 0;
          end
        end else begin
          m_mem[k][3'(m_sweep[k])] = CLR_V[k];
          m_sweep[k] = m_sweep[k] + 1;
          if (m_sweep[k] == 8) m_ready[k] = 1'b1;
        end
        if (LAT[k] == 1) begin
          m_vld[k] = rd_now;
          if (rd_now) m_data[k] = res;
        end else begin
          m_vld[k] = p_vld[k];
          if (p_vld[k]) m_data[k] = p_data[k];
          p_vld[k] = rd_now;
          if (rd_now) p_data[k] = res;
        end
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear_req = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b1; wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ready_o[k] !== 1'b0 || rd_valid_o[k] !== 1'b0 || rd_data_o[k] !== 16'h0) begin
        failures++;
        $display("FAIL reset_out dut%0d got rdy=%b vld=%b data=%h exp 0/0/0000",
                 k, ready_o[k], rd_valid_o[k], rd_data_o[k]);
      end
    end
    rst_n = 1'b1; rd_en = 1'b1; rd_addr = 3'd5;
    for (int c = 0; c < 8; c++) begin
      cycle();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd_valid_o[k] !== 1'b0 || ready_o[k] !== (c == 7)) begin
          failures++;
          $display("FAIL sweep dut%0d cyc=%0d got rdy=%b vld=%b exp rdy=%b vld=0",
                   k, c, ready_o[k], rd_valid_o[k], (c == 7));
        end
      end
    end
    cycle();
    rd_en = 1'b0;
    repeat (2) cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_data_o[k] !== CLR_V[k] || rd_data_o[k] !== m_data[k]) begin
        failures++;
        $display("FAIL first_read dut%0d got %h exp %h", k, rd_data_o[k], CLR_V[k]);
      end
    end
  endtask

  task automatic test_byte_enable();
    idle();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hABCD; wr_be = 2'b11;
    cycle();
    wr_data = 16'h1234; wr_be = 2'b01;
    cycle();
    wr_data = 16'hFFFF; wr_be = 2'b00;
    cycle();
    idle(); rd_en = 1'b1; rd_addr = 3'd3;
    cycle();
    idle();
    repeat (2) cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_data_o[k] !== 16'hAB34 || ready_o[k] !== m_ready[k] || rd_valid_o[k] !== m_vld[k]) begin
        failures++;
        $display("FAIL byte_enable dut%0d got data=%h rdy=%b vld=%b exp data=ab34 rdy=%b vld=%b",
                 k, rd_data_o[k], ready_o[k], rd_valid_o[k], m_ready[k], m_vld[k]);
      end
    end
  endtask

  task automatic test_collision();
    logic [15:0] exp_v;
    idle();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1111; wr_be = 2'b11;
    cycle();
    wr_data = 16'h2222; rd_en = 1'b1; rd_addr = 3'd2;
    cycle();
    idle();
    repeat (2) cycle();
    for (int k = 0; k < 4; k++) begin
      exp_v = (MODE[k] == 1) ? 16'h2222 : 16'h1111;
      checks++;
      if (rd_data_o[k] !== exp_v) begin
        failures++;
        $display("FAIL collision dut%0d got %h exp %h", k, rd_data_o[k], exp_v);
      end
    end
    rd_en = 1'b1; rd_addr = 3'd2;
    cycle();
    idle();
    repeat (2) cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_data_o[k] !== 16'h2222) begin
        failures++;
        $display("FAIL collision_after dut%0d got %h exp 2222", k, rd_data_o[k]);
      end
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h5566; wr_be = 2'b10;
    rd_en = 1'b1; rd_addr = 3'd2;
    cycle();
    idle();
    repeat (2) cycle();
    for (int k = 0; k < 4; k++) begin
      exp_v = (MODE[k] == 1) ? 16'h5522 : 16'h2222;
      checks++;
      if (rd_data_o[k] !== exp_v) begin
        failures++;
        $display("FAIL collision_partial dut%0d got %h exp %h", k, rd_data_o[k], exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    logic        exp_vld;
    int          idx;
    idle();
    for (int a = 0; a < 3; a++) begin
      vals[a] = 16'($urandom);
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = vals[a]; wr_be = 2'b11;
      cycle();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      rd_en   = (i < 3);
      rd_addr = 3'(i % 3);
      cycle();
      for (int k = 0; k < 4; k++) begin
        exp_vld = (i >= LAT[k] - 1) && (i <= LAT[k] + 1);
        idx     = i - (LAT[k] - 1);
        checks++;
        if (rd_valid_o[k] !== exp_vld || (exp_vld && rd_data_o[k] !== vals[idx])) begin
          failures++;
          $display("FAIL back_to_back dut%0d cyc=%0d got vld=%b data=%h exp vld=%b data=%h",
                   k, i, rd_valid_o[k], rd_data_o[k], exp_vld, exp_vld ? vals[idx] : 16'h0);
        end
      end
    end
  endtask

  task automatic test_clear();
    idle();
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 16'($urandom); wr_be = 2'b11;
      cycle();
    end
    clear_req = 1'b1; wr_addr = 3'd7; wr_data = 16'h7777;
    cycle();
    clear_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      wr_en = 1'b1; wr_addr = 3'($urandom); wr_data = 16'($urandom); wr_be = 2'b11;
      rd_en = 1'b1; rd_addr = 3'($urandom);
      cycle();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd_valid_o[k] !== 1'b0 || ready_o[k] !== (c == 7) || ready_o[k] !== m_ready[k]) begin
          failures++;
          $display("FAIL clear_sweep dut%0d cyc=%0d got rdy=%b vld=%b exp rdy=%b vld=0",
                   k, c, ready_o[k], rd_valid_o[k], (c == 7));
        end
      end
    end
    idle();
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_addr = 3'(a);
      cycle();
      idle();
      repeat (2) cycle();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd_data_o[k] !== CLR_V[k]) begin
          failures++;
          $display("FAIL clear_value dut%0d addr=%0d got %h exp %h", k, a, rd_data_o[k], CLR_V[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear_req = ($urandom_range(0, 49) == 0);
      wr_en     = 1'($urandom);
      wr_addr   = 3'($urandom);
      wr_data   = 16'($urandom);
      wr_be     = 2'($urandom);
      rd_en     = 1'($urandom);
      rd_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
      cycle();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ready_o[k] !== m_ready[k] || rd_valid_o[k] !== m_vld[k] || rd_data_o[k] !== m_data[k]) begin
          failures++;
          $display("FAIL random dut%0d cyc=%0d got rdy=%b vld=%b data=%h exp rdy=%b vld=%b data=%h",
                   k, i, ready_o[k], rd_valid_o[k], rd_data_o[k], m_ready[k], m_vld[k], m_data[k]);
        end
      end
    end
    idle();
    for (int c = 0; c < 20 && !(ready_o[0] && ready_o[1] && ready_o[2] && ready_o[3]); c++) begin
      cycle();
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ready_o[k] !== 1'b1 || m_ready[k] !== 1'b1) begin
        failures++;
        $display("FAIL drain_ready dut%0d got rdy=%b exp 1", k, ready_o[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = 3'($urandom);
      cycle();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd_valid_o[k] !== m_vld[k] || rd_data_o[k] !== m_data[k]) begin
          failures++;
          $display("FAIL burst dut%0d cyc=%0d got vld=%b data=%h exp vld=%b data=%h",
                   k, i, rd_valid_o[k], rd_data_o[k], m_vld[k], m_data[k]);
        end
      end
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_valid_o[k] !== 1'b0 || rd_data_o[k] !== 16'h0 || ready_o[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid dut%0d got vld=%b data=%h rdy=%b exp 0/0000/0",
                 k, rd_valid_o[k], rd_data_o[k], ready_o[k]);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 11; c++) begin
      rd_addr = 3'($urandom);
      cycle();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ready_o[k] !== m_ready[k] || rd_valid_o[k] !== m_vld[k] || rd_data_o[k] !== m_data[k] ||
            (c < 8 && (rd_valid_o[k] !== 1'b0 || ready_o[k] !== (c == 7)))) begin
          failures++;
          $display("FAIL reset_release dut%0d cyc=%0d got rdy=%b vld=%b data=%h exp rdy=%b vld=%b data=%h",
                   k, c, ready_o[k], rd_valid_o[k], rd_data_o[k], m_ready[k], m_vld[k], m_data[k]);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_clear();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
